// File: rtl/memory_responder.sv
// memory_responder: word-addressed memory that completes one read or write per request, with a programmable wait-state delay.
// Latency: WAIT_STATES+1 cycles from the accept edge to the mem_ready pulse; a held request repeats once every WAIT_STATES+3 cycles.
// Backpressure: requests are sampled only in IDLE; anything raised during WAIT or DONE is dropped, never queued.
module memory_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] memory_data,
  output logic        mem_ready,
  output logic        busy,
  output logic        addr_error
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          is_wr_q, is_wr_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          aerr_q, aerr_d;
  logic          mem_we;
  logic          req_err;
  logic [31:0]   mem_q [DEPTH_WORDS];

  // A request is rejected if misaligned, beyond the array, or asking for both read and write.
  assign req_err = (address[1:0] != 2'b00) || (address[31:AW+2] != '0) || (mem_read && mem_write);

  // Next-state and registered-output decode; the access itself happens on the WAIT->DONE edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    busy_d  = busy_q;
    aerr_d  = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          idx_d   = address[AW+1:2];
          wdata_d = write_data;
          is_wr_d = mem_write;
          err_d   = req_err;
          cnt_d   = 4'(WAIT_STATES);
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_DONE;
          ready_d = 1'b1;
          aerr_d  = err_q;
          if (!err_q) begin
            if (is_wr_q) mem_we = 1'b1;
            else         rdata_d = mem_q[idx_q];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers; reset aborts any access still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      is_wr_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      aerr_q  <= aerr_d;
    end
  end

  // Storage array keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= wdata_q;
  end

  assign memory_data = rdata_q;
  assign mem_ready   = ready_q;
  assign busy        = busy_q;
  assign addr_error  = aerr_q;

endmodule
